// File: rtl/reduction_tree_pipe_if.sv
// Operand/result handshake bundle for reduction_tree_pipe.
// The acc tag exists only when REDUCTION_ACC_EN is defined.
interface reduction_tree_pipe_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              sign;
`ifdef REDUCTION_ACC_EN
    logic              acc;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] S;

    modport master (
`ifdef REDUCTION_ACC_EN
        output acc,
`endif
        output in_valid, A, B, sign, out_ready,
        input  in_ready, out_valid, S
    );

    modport slave (
`ifdef REDUCTION_ACC_EN
        input  acc,
`endif
        input  in_valid, A, B, sign, out_ready,
        output in_ready, out_valid, S
    );
endinterface

// File: rtl/reduction_tree_pipe.sv
// Pipelined lane-sum reduction tree: one register stage per tree level, global stall.
// Define REDUCTION_ACC_EN to compile in the running accumulator on the output stage.
module reduction_tree_pipe #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    reduction_tree_pipe_if.slave bus
);
    localparam int N  = (2 * DATA_W) / LANE_W;
    localparam int L  = $clog2(N);
    localparam int WF = LANE_W + L - 1;

    if ((N < 2) || ((N & (N - 1)) != 0) || (((2 * DATA_W) % LANE_W) != 0)) begin : g_bad_lanes
        $error("reduction_tree_pipe: 2*DATA_W/LANE_W must be a power of two >= 2");
    end
    if (DATA_W < LANE_W + L) begin : g_bad_width
        $error("reduction_tree_pipe: DATA_W must be >= LANE_W + log2(lanes)");
    end

    logic                adv_s;
    logic                out_valid_q;
    logic [DATA_W-1:0]   s_q;
    logic [DATA_W-1:0]   s_d;
    logic [2*DATA_W-1:0] ops_s;

    assign adv_s = !out_valid_q || bus.out_ready;
    assign ops_s = {bus.B, bus.A};

    // Inner tree levels; the last level is folded into the output register below.
    for (genvar s = 0; s < L - 1; s++) begin : g_lvl
        localparam int W = LANE_W + s + 1;
        localparam int M = N >> (s + 1);

        logic [W-2:0] src_s [2*M];
        logic         vld_in_s;
        logic         sgn_in_s;
        logic [W-1:0] sum_d [M];
        logic [W-1:0] sum_q [M];
        logic         vld_q;
        logic         sgn_q;
`ifdef REDUCTION_ACC_EN
        logic         acc_in_s;
        logic         acc_tag_q;
`endif

        if (s == 0) begin : g_src
            // Level 0 reads raw lanes: A lanes first, then B lanes.
            always_comb begin
                for (int j = 0; j < 2 * M; j++) begin
                    src_s[j] = ops_s[j*LANE_W +: LANE_W];
                end
            end
            assign vld_in_s = bus.in_valid;
            assign sgn_in_s = bus.sign;
`ifdef REDUCTION_ACC_EN
            assign acc_in_s = bus.acc;
`endif
        end else begin : g_src
            // Deeper levels read the previous level's registered partial sums.
            always_comb begin
                for (int j = 0; j < 2 * M; j++) begin
                    src_s[j] = g_lvl[s-1].sum_q[j];
                end
            end
            assign vld_in_s = g_lvl[s-1].vld_q;
            assign sgn_in_s = g_lvl[s-1].sgn_q;
`ifdef REDUCTION_ACC_EN
            assign acc_in_s = g_lvl[s-1].acc_tag_q;
`endif
        end

        // Pairwise add, each operand widened by one bit per the beat's sign mode.
        always_comb begin
            for (int j = 0; j < M; j++) begin
                sum_d[j] = {sgn_in_s & src_s[2*j][W-2], src_s[2*j]}
                         + {sgn_in_s & src_s[2*j+1][W-2], src_s[2*j+1]};
            end
        end

        // Level register: sums and tags load only with a valid beat, bubbles pass through.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                sgn_q <= 1'b0;
`ifdef REDUCTION_ACC_EN
                acc_tag_q <= 1'b0;
`endif
                for (int j = 0; j < M; j++) begin
                    sum_q[j] <= {W{1'b0}};
                end
            end else if (adv_s) begin
                vld_q <= vld_in_s;
                if (vld_in_s) begin
                    sgn_q <= sgn_in_s;
`ifdef REDUCTION_ACC_EN
                    acc_tag_q <= acc_in_s;
`endif
                    sum_q <= sum_d;
                end
            end
        end
    end

    logic [WF-1:0]     fa_s;
    logic [WF-1:0]     fb_s;
    logic              fvld_s;
    logic              fsgn_s;
    logic [DATA_W-1:0] tree_s;

    assign fa_s   = g_lvl[L-2].sum_q[0];
    assign fb_s   = g_lvl[L-2].sum_q[1];
    assign fvld_s = g_lvl[L-2].vld_q;
    assign fsgn_s = g_lvl[L-2].sgn_q;
    assign tree_s = {{(DATA_W-WF){fsgn_s & fa_s[WF-1]}}, fa_s}
                  + {{(DATA_W-WF){fsgn_s & fb_s[WF-1]}}, fb_s};

`ifdef REDUCTION_ACC_EN
    logic              facc_s;
    logic [DATA_W-1:0] acc_q;

    assign facc_s = g_lvl[L-2].acc_tag_q;

    // Tagged beats add onto the previous accumulated result.
    always_comb begin
        if (facc_s) begin
            s_d = acc_q + tree_s;
        end else begin
            s_d = tree_s;
        end
    end

    // Output stage; accumulator follows every loaded result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= {DATA_W{1'b0}};
            acc_q       <= {DATA_W{1'b0}};
        end else if (adv_s) begin
            out_valid_q <= fvld_s;
            if (fvld_s) begin
                s_q   <= s_d;
                acc_q <= s_d;
            end
        end
    end
`else
    assign s_d = tree_s;

    // Output stage; S holds its last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= {DATA_W{1'b0}};
        end else if (adv_s) begin
            out_valid_q <= fvld_s;
            if (fvld_s) begin
                s_q <= s_d;
            end
        end
    end
`endif

    assign bus.in_ready  = adv_s;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
endmodule
